pipelined_addsub: RTL
=====================

# pipelined_addsub

Parametrised, pipelined adder/subtractor for the CPU datapath. It splits a WIDTH-bit add into STAGES carry-chained chunks, one chunk per pipeline stage, so wide adds meet timing at full throughput. Unlike the combinational 32-bit ripple adder it supersedes, it supports subtract and add-with-carry, and reports carry-out, signed overflow and zero. It sits between the operand-fetch and writeback stages behind a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 32: operand/result width; must be a multiple of STAGES.
- STAGES, 4: pipeline depth and chunk count, 1..WIDTH; CHUNK = WIDTH/STAGES.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of every in-flight transaction.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  pipeline can accept this cycle.
- op  in  2  0=ADD, 1=SUB, 2=ADDC (uses cin), 3=SUBB (a-b-!cin, borrow form).
- a, b  in  WIDTH  operands.
- cin  in  1  carry-in for ADDC/SUBB; ignored otherwise.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (for SUB: 1 = no borrow).
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- Operand prep at accept: b_eff = b for ADD/ADDC, ~b for SUB/SUBB; c0 = 0 (ADD), 1 (SUB), cin (ADDC), cin (SUBB).
- Stage k (0..STAGES-1) adds chunk k of a and b_eff with the carry registered from stage k-1 (c0 for stage 0). Upper chunks are carried forward unprocessed, and completed lower sum chunks are carried forward in the stage registers (skew/deskew).
- Final stage registers sum, cout = carry out of the top chunk, and ovf = carry into MSB XOR carry out of MSB. zero is computed combinationally from the registered sum.
- Arithmetic is modulo 2^WIDTH. There are no saturating modes.
- Each stage holds a valid bit. A global advance signal is defined as advance = !out_valid || out_ready.
  - All stages shift together when advance is high.
  - Bubbles are not collapsed.
- in_ready = advance. A beat is accepted when in_valid && in_ready.
- Reset (rst_n low, any time): all valid bits go to 0 immediately. Data registers are don't-care.
- flush: clears all valid bits at the next edge, overriding a same-cycle accept and advance. A beat offered during flush is dropped.
- When out_valid is high and out_ready is low, sum/cout/ovf/zero hold stable and the whole pipe stalls.

## Timing
- Reset values: out_valid=0, in_ready=1, sum=0, cout=0, ovf=0, zero=1.
- Latency: a beat accepted at edge t gives out_valid high after edge t+STAGES-1, with no stalls and STAGES≥1. STAGES=1 is a single registered adder with 1-cycle latency.
- Throughput is one result per cycle while out_ready=1.
- in_ready depends combinationally on out_ready. No other combinational path exists from inputs to outputs.
- A stall of N cycles delays every in-flight result by exactly N cycles and drops none.
- Simultaneous out accept and in accept in the same cycle is legal and sustains full rate.

## Structure
- Package alu_pkg holds the op encodings OP_ADD/OP_SUB/OP_ADDC/OP_SUBB. The ALU reuses the same package.
- Sub-module add_chunk: combinational CHUNK-bit carry-chained adder (a, b, ci → s, co, c_msb_in), instantiated STAGES times via generate. c_msb_in feeds overflow in the top chunk.
- Elaboration check: WIDTH % STAGES must be 0; otherwise fatal.

## Test plan
Bench uses WIDTH=32, STAGES=4.
- Reset then ADD a=0x0000_0001, b=0xFFFF_FFFF → sum=0, cout=1, ovf=0, zero=1; out_valid exactly 4 cycles after accept.
- SUB a=0x8000_0000, b=1 → sum=0x7FFF_FFFF, cout=1, ovf=1. ADD 0x7FFF_FFFF+1 → 0x8000_0000, ovf=1, cout=0.
- ADDC a=0xFFFF, b=0, cin=1 → 0x0001_0000, which checks inter-chunk carry. SUBB a=5, b=5, cin=0 → 0xFFFF_FFFF, cout=0.
- Back-to-back stream of 16 random beats with out_ready toggled pseudo-randomly → results in order, none lost or duplicated, outputs stable while stalled, matches a reference model.
- 3 beats in flight, assert flush → no out_valid for them. A beat accepted the cycle after flush emerges normally.
- rst_n pulsed low asynchronously mid-stream → out_valid drops without a clock edge. After release, a new ADD 2+3 → sum=5.
- Repeat the random stream at STAGES=1 and STAGES=32 → identical results; latency of 1 and 32 respectively.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and small helpers for the datapath arithmetic units.
package alu_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ADDC = 2'd2,
    OP_SUBB = 2'd3
  } op_e;

  // True for the two ops that add the inverted second operand.
  function automatic logic op_is_sub(input op_e o);
    return (o == OP_SUB) || (o == OP_SUBB);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice; exposes the carry into its MSB for overflow.
module add_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] full;

  // One extra bit captures the carry out of the slice.
  always_comb begin
    full     = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(ci);
    s        = full[CHUNK-1:0];
    co       = full[CHUNK];
    c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: one CHUNK-bit slice per stage, carry registered between stages.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  if ((STAGES == 0) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $fatal(1, "pipelined_addsub: WIDTH must be a nonzero multiple of STAGES");
  end

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Stage registers: operands travel with the partial sum (skew/deskew).
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];
  logic              ovf_q;

  // Per-stage adder inputs and results.
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [WIDTH-1:0]  s_nx [STAGES];
  logic              c_in [STAGES];
  logic [CHUNK-1:0]  s_ch [STAGES];
  logic              co_ch [STAGES];
  logic              cm_ch [STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // Operand prep: subtraction adds the inverted operand with carry-in set.
  always_comb begin
    b_eff = op_is_sub(op_e'(op)) ? ~b : b;
    c0    = 1'b0;
    case (op_e'(op))
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  c0 = 1'b1;
      OP_ADDC: c0 = cin;
      OP_SUBB: c0 = cin;
      default: c0 = 1'b0;
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);

    if (k == 0) begin : g_first
      assign a_in[k] = a;
      assign b_in[k] = b_eff;
      assign c_in[k] = c0;
      assign s_in[k] = '0;
    end else begin : g_next
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign s_in[k] = s_q[k-1];
    end

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (a_in[k][k*CHUNK +: CHUNK]),
      .b        (b_in[k][k*CHUNK +: CHUNK]),
      .ci       (c_in[k]),
      .s        (s_ch[k]),
      .co       (co_ch[k]),
      .c_msb_in (cm_ch[k])
    );

    // Drop this stage's chunk into the partial sum carried forward.
    assign s_nx[k] = (s_in[k] & ~MASK) | (WIDTH'(s_ch[k]) << (k * CHUNK));
  end

  // Pipe shift: valid bits honour flush; data moves whenever the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        s_q[i] <= '0;
        c_q[i] <= 1'b0;
      end
    end else begin
      if (flush) begin
        vld_q <= '0;
      end else if (advance) begin
        vld_q[0] <= accept;
        for (int i = 1; i < STAGES; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
      if (advance) begin
        for (int i = 0; i < STAGES; i++) begin
          a_q[i] <= a_in[i];
          b_q[i] <= b_in[i];
          s_q[i] <= s_nx[i];
          c_q[i] <= co_ch[i];
        end
        ovf_q <= cm_ch[STAGES-1] ^ co_ch[STAGES-1];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = (s_q[STAGES-1] == '0);

endmodule
